// File: rtl/reg_pipe_vr.sv
// Chain of DEPTH valid/ready register stages with bubble collapsing and synchronous flush.
// Optional occupancy counter port is enabled by defining REG_PIPE_OCC_EN.
module reg_pipe_vr #(
   parameter int                 DATA_W     = 32,
   parameter int                 DEPTH      = 2,
   parameter logic [DATA_W-1:0]  PRESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic                         flush,
   input  logic [DATA_W-1:0]            din,
   input  logic                         din_valid,
   output logic                         din_ready,
   output logic [DATA_W-1:0]            dout,
   output logic                         dout_valid,
   input  logic                         dout_ready
`ifdef REG_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DEPTH:0]    rdy;

   // A stage can take new data if it is empty or its occupant moves on,
   // which folds to "any empty stage at or after it, or the consumer is ready".
   always_comb begin
      logic acc;
      acc        = dout_ready;
      rdy[DEPTH] = acc;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         acc    = !valid_q[i] || acc;
         rdy[i] = acc;
      end
   end

   assign din_ready  = rdy[0] && !flush;
   assign dout       = data_q[DEPTH-1];
   assign dout_valid = valid_q[DEPTH-1] && !flush;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
               valid_d[i] = valid_q[i-1];
               if (valid_q[i-1]) data_d[i] = data_q[i-1];
            end
         end
         if (rdy[0]) begin
            valid_d[0] = din_valid;
            if (din_valid) data_d[0] = din;
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= PRESET_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

`ifdef REG_PIPE_OCC_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             inXfer, outXfer;
   logic [OCC_W-1:0] occ_q;

   assign inXfer    = din_valid && din_ready;
   assign outXfer   = dout_valid && dout_ready;
   assign occupancy = occ_q;

   // Tracks popcount(valid) incrementally; a simultaneous push and pop cancel out.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else if (inXfer && !outXfer) begin
         occ_q <= occ_q + OCC_W'(1);
      end else if (!inXfer && outXfer) begin
         occ_q <= occ_q - OCC_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_reg_pipe_vr.sv
// Self-checking bench for reg_pipe_vr (DEPTH=3): item-level queue model plus directed literal checks.
// Occupancy is checked only when REG_PIPE_OCC_EN is defined.
module tb_reg_pipe_vr;

   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 3;
   localparam logic [31:0] PRESET = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              arst;
   logic              flush;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
`ifdef REG_PIPE_OCC_EN
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

   int nChecks = 0;
   int nFails  = 0;
   bit checkEn = 1'b0;

   // Model: in-flight items oldest first, each with the stage index it sits in.
   logic [31:0] mData [$];
   int          mPos  [$];

   reg_pipe_vr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRESET_VAL(PRESET)) dut (
      .clk(clk), .arst(arst), .flush(flush),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef REG_PIPE_OCC_EN
      , .occupancy(occupancy)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Lowest stage index that will be occupied after this edge's moves (DEPTH if none).
   function automatic int limitAfterMoves(input bit rdyOut);
      int lim   = DEPTH;
      int start = 0;
      if (mPos.size() > 0 && mPos[0] == DEPTH - 1 && rdyOut) start = 1;
      for (int k = start; k < mPos.size(); k++) begin
         lim = (mPos[k] + 1 < lim) ? mPos[k] + 1 : mPos[k];
      end
      return lim;
   endfunction

   task automatic modelUpdate();
      int lim;
      if (flush) begin
         mData.delete();
         mPos.delete();
         return;
      end
      lim = limitAfterMoves(dout_ready);
      if (mPos.size() > 0 && mPos[0] == DEPTH - 1 && dout_ready) begin
         void'(mData.pop_front());
         void'(mPos.pop_front());
      end
      begin
         int l = DEPTH;
         for (int k = 0; k < mPos.size(); k++) begin
            if (mPos[k] + 1 < l) mPos[k] = mPos[k] + 1;
            l = mPos[k];
         end
      end
      if (din_valid && lim > 0) begin
         mData.push_back(din);
         mPos.push_back(0);
      end
   endtask

   // Compare process: every cycle the DUT is out of reset, outputs are checked against the model.
   always @(negedge clk) begin
      if (checkEn && !arst) begin
         bit expValid;
         bit expReady;
         expValid = !flush && mPos.size() > 0 && mPos[0] == DEPTH - 1;
         expReady = !flush && (limitAfterMoves(dout_ready) > 0);
         checkOutput("model dout_valid", 32'(dout_valid), 32'(expValid));
         checkOutput("model din_ready", 32'(din_ready), 32'(expReady));
         if (expValid) checkOutput("model dout", dout, mData[0]);
`ifdef REG_PIPE_OCC_EN
         checkOutput("model occupancy", 32'(occupancy), 32'(mData.size()));
`endif
      end
   end

   task automatic applyStimulus(input bit dv, input logic [31:0] d, input bit dr, input bit fl);
      din_valid  = dv;
      din        = d;
      dout_ready = dr;
      flush      = fl;
      @(negedge clk);
   endtask

   task automatic clockEdge();
      @(posedge clk);
      if (!arst) modelUpdate();
      #1;
   endtask

   task automatic checkOcc(input string name, input int exp);
`ifdef REG_PIPE_OCC_EN
      checkOutput(name, 32'(occupancy), 32'(exp));
`endif
   endtask

   initial begin
      logic [31:0] expSeq [4];
      arst = 1'b1; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset dout_valid", 32'(dout_valid), 32'd0);
      checkOutput("reset dout", dout, 32'hDEAD_BEEF);
      checkOutput("reset din_ready", 32'(din_ready), 32'd1);
      checkOcc("reset occupancy", 0);
      arst = 1'b0;
      checkEn = 1'b1;

      // Streaming: first output two edges after the first push, then back to back.
      expSeq = '{32'd1, 32'd2, 32'd3, 32'd4};
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c < 4, 32'(c + 1), 1'b1, 1'b0);
         checkOutput("stream din_ready", 32'(din_ready), 32'd1);
         if (c >= 3 && c <= 6) checkOutput("stream dout", dout, expSeq[c-3]);
         checkOutput("stream dout_valid", 32'(dout_valid), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
         clockEdge();
      end

      // Backpressure to full, then a simultaneous pop/push, then drain.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 32'(10 + c), 1'b0, 1'b0);
         clockEdge();
      end
      applyStimulus(1'b1, 32'd13, 1'b0, 1'b0);
      checkOutput("full din_ready", 32'(din_ready), 32'd0);
      checkOutput("full dout", dout, 32'd10);
      checkOcc("full occupancy", 3);
      clockEdge();
      applyStimulus(1'b1, 32'd13, 1'b1, 1'b0);
      checkOutput("simul din_ready", 32'(din_ready), 32'd1);
      checkOutput("simul dout", dout, 32'd10);
      clockEdge();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
         checkOutput("drain dout", dout, 32'(11 + c));
         clockEdge();
      end
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("drained dout_valid", 32'(dout_valid), 32'd0);
      clockEdge();

      // Bubble collapse while stalled.
      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0); clockEdge();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0); clockEdge();
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0); clockEdge();
      applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
      checkOutput("bubble dout", dout, 32'hA);
      checkOutput("bubble din_ready", 32'(din_ready), 32'd1);
      checkOcc("bubble occupancy", 2);
      clockEdge();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("bubble full din_ready", 32'(din_ready), 32'd0);
      checkOcc("bubble full occupancy", 3);
      clockEdge();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
         checkOutput("bubble drain dout", dout, 32'(32'hA + c));
         clockEdge();
      end

      // Flush drops held items and the offered input.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 32'(32'h20 + c), 1'b0, 1'b0);
         clockEdge();
      end
      applyStimulus(1'b1, 32'd9, 1'b1, 1'b1);
      checkOutput("flush din_ready", 32'(din_ready), 32'd0);
      checkOutput("flush dout_valid", 32'(dout_valid), 32'd0);
      clockEdge();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
         checkOutput("post-flush dout_valid", 32'(dout_valid), 32'd0);
         checkOcc("post-flush occupancy", 0);
         clockEdge();
      end

      // Randomized traffic with occasional flushes.
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 19) == 0);
         clockEdge();
      end

      // Asynchronous reset with a full pipe.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
         clockEdge();
      end
      #2;
      arst = 1'b1;
      #1;
      checkOutput("arst dout_valid", 32'(dout_valid), 32'd0);
      checkOutput("arst dout", dout, 32'hDEAD_BEEF);
      checkOcc("arst occupancy", 0);
      mData.delete();
      mPos.delete();
      repeat (2) clockEdge();
      arst = 1'b0;

      for (int c = 0; c < 100; c++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 5, 1'b0);
         clockEdge();
      end

      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
